spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//   SPI responder (mode 0: CPOL=0, CPHA=0, MSB first): the far end of the team's SPI master/clk_div.
//   Oversamples sclk/cs_n/mosi in the clk domain, shifts in a frame of n_bits and drives miso from a preloaded word.
//   Hands the received word to the system with a 1-cycle rx_valid pulse.
//   Takes the transmit word through a tx_valid/tx_ready handshake.
// PARAMETERS
//   SPI_MAXLEN   16  max frame length in bits; width of tx_data/rx_data
//   SYNC_STAGES  2   synchroniser depth for sclk, cs_n, mosi (>=2)
// PORTS
//   clk          in   1                    system clock
//   rst          in   1                    async reset, active-low
//   sclk         in   1                    SPI clock from master (async)
//   cs_n         in   1                    chip select, active-low (async)
//   mosi         in   1                    master-out data (async)
//   miso         out  1                    slave-out data
//   miso_oe      out  1                    miso output enable (tri-state control at pad)
//   n_bits       in   $clog2(SPI_MAXLEN)+1 frame length; latched at frame start
//   tx_data      in   SPI_MAXLEN           word to transmit, right-justified
//   tx_valid     in   1                    tx_data valid; hold until tx_ready
//   tx_ready     out  1                    1-cycle accept pulse
//   rx_data      out  SPI_MAXLEN           last complete received word, right-justified
//   rx_valid     out  1                    1-cycle pulse: rx_data updated
//   frame_abort  out  1                    1-cycle pulse: cs_n rose mid-frame
//   tx_underrun  out  1                    1-cycle pulse: frame started with tx_valid low
// BEHAVIOUR
// - Reset (rst=0, async) values:
//   - miso=0, miso_oe=0, tx_ready=0, rx_data=0, rx_valid=0, frame_abort=0, tx_underrun=0.
//   - Sync chains reset cs_n high, sclk low; state=IDLE.
// - Sync and edge detect:
//   - sclk, cs_n, mosi each pass through SYNC_STAGES flops; edges detected on the sync outputs vs a 1-flop delay.
//   - Required: sclk high and low phases each >= SYNC_STAGES+1 clk periods.
// - Effective length L:
//   - L = n_bits latched at frame start.
//   - n_bits==0 or n_bits>SPI_MAXLEN gives L=SPI_MAXLEN.
// - FSM IDLE -> SHIFT -> DONE:
//   - IDLE, on cs_n sync falling edge:
//     - Latch L. If tx_valid: tx_ready=1 this cycle, load tx_sh<=tx_data. Else tx_sh<=0, tx_underrun=1.
//     - Next cycle: miso=bit L-1 of the loaded word, miso_oe=1; bit_cnt=0; go SHIFT.
//   - SHIFT, sclk rising: rx_sh<={rx_sh,mosi_sync}; bit_cnt++.
//     - If this was bit L (bit_cnt==L-1 before increment): rx_data<=rx_sh result, zero-extended above L.
//     - Then rx_valid=1 for the next cycle only; go DONE.
//   - SHIFT, sclk falling: tx_sh shifts left; miso=next bit. The falling edge before the first rising edge cannot occur (CPOL=0).
//   - SHIFT, cs_n rising before L bits:
//     - frame_abort=1 for 1 cycle; rx_data unchanged; no rx_valid; go IDLE.
//   - DONE: miso holds last bit; further sclk edges ignored; on cs_n rising go IDLE.
//   - IDLE: miso_oe=0, miso=0.
// - Simultaneous events:
//   - cs_n rise in same cycle as last sclk rise: frame completes (rx_valid), no frame_abort.
//   - cs_n fall detected while in DONE: treated as new frame only after IDLE is re-entered (cs_n must be high >=1 sync'd cycle).
// - tx_data is sampled only at the accept cycle; changes afterwards do not affect the frame in flight.
// - rx_valid, frame_abort, tx_underrun, tx_ready are never high for more than 1 consecutive cycle.
// - No rx back-pressure; rx_data is overwritten by the next completed frame.
// TESTING
//   1. n_bits=8, tx_data=0xA5 valid, master sends 0x3C (sclk=clk/8) ->
//      miso sequence 1,0,1,0,0,1,0,1; rx_data=0x003C; one rx_valid pulse; one tx_ready pulse.
//   2. n_bits=0 (=>16), tx_data=0xBEEF, master sends 0x1234 -> master receives 0xBEEF; rx_data=0x1234.
//   3. n_bits=8, cs_n raised after 5 sclk rises ->
//      frame_abort pulse; rx_valid stays 0; rx_data keeps previous value; next full frame correct.
//   4. tx_valid=0 at frame start, master sends 0xFF ->
//      tx_underrun pulse, tx_ready stays 0, miso all 0, rx_data=0x00FF.
//   5. rst asserted after 3 bits ->
//      all outputs to reset values immediately; next frame (0x5A) received correctly.
//   6. Two back-to-back 8-bit frames, cs_n high 4 clk between, extra sclk pulse after bit 8 ->
//      two rx_valid pulses, extra pulse ignored.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (CPOL=0, CPHA=0, MSB first).
// sclk, cs_n and mosi are oversampled in the clk domain. Each frame shifts in
// L bits and shifts out a word preloaded through a tx_valid/tx_ready handshake.
//
// State table:
//   state   | meaning
//   S_IDLE  | cs_n high or no frame started; miso tri-stated and driven 0
//   S_SHIFT | frame in progress; sample mosi on sclk rise, advance miso on sclk fall
//   S_DONE  | L bits received; miso holds the last bit, waits for cs_n to go high
//
// Ports:
//   clk, rst            system clock, async active-low reset
//   sclk, cs_n, mosi    asynchronous SPI inputs from the master
//   miso, miso_oe       slave data out and its pad output enable
//   n_bits              frame length, latched at frame start (0 or >SPI_MAXLEN -> SPI_MAXLEN)
//   tx_data, tx_valid   word to transmit (right-justified); held until tx_ready
//   tx_ready            1-cycle accept pulse
//   rx_data, rx_valid   last complete received word (right-justified), 1-cycle update pulse
//   frame_abort         1-cycle pulse when cs_n rises mid-frame
//   tx_underrun         1-cycle pulse when a frame starts without tx_valid
module spi_slave #(
    parameter int SPI_MAXLEN  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk,
    input  logic                          cs_n,
    input  logic                          mosi,
    output logic                          miso,
    output logic                          miso_oe,
    input  logic [$clog2(SPI_MAXLEN):0]   n_bits,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic                          rx_valid,
    output logic                          frame_abort,
    output logic                          tx_underrun
);

    localparam int IW = $clog2(SPI_MAXLEN);
    localparam int LW = IW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [SPI_MAXLEN-1:0]  r_tx_sh;
    logic [SPI_MAXLEN-1:0]  r_rx_sh;
    logic [IW-1:0]          r_len_m1;
    logic [IW-1:0]          r_bit_cnt;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_start;
    logic                   w_last_rise;
    logic                   w_abort;
    logic [LW-1:0]          w_len;
    logic [SPI_MAXLEN-1:0]  w_rx_next;

    // Synchronisers: cs_n resets high (deselected), sclk/mosi low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    always_comb begin
        if ((n_bits == '0) || (n_bits > LW'(SPI_MAXLEN)))
            w_len = LW'(SPI_MAXLEN);
        else
            w_len = n_bits;
    end

    // The last rise wins over a simultaneous cs_n rise: the frame completes.
    assign w_start     = (r_state == S_IDLE) & w_cs_fall;
    assign w_last_rise = (r_state == S_SHIFT) & w_sclk_rise & (r_bit_cnt == r_len_m1);
    assign w_abort     = (r_state == S_SHIFT) & w_cs_rise & ~w_last_rise;
    // rx_sh is cleared at frame start, so bits above L stay zero.
    assign w_rx_next   = SPI_MAXLEN'({r_rx_sh, w_mosi_s});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // DONE leaves on cs_n high (level) so a cs_n rise coinciding with the
    // last sclk rise still returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_last_rise)    w_state_nxt = S_DONE;
                else if (w_cs_rise) w_state_nxt = S_IDLE;
            end
            S_DONE:  if (w_cs_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        miso        = 1'b0;
        miso_oe     = 1'b0;
        tx_ready    = 1'b0;
        tx_underrun = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    tx_ready    = tx_valid;
                    tx_underrun = ~tx_valid;
                end
            end
            S_SHIFT, S_DONE: begin
                miso_oe = 1'b1;
                miso    = r_tx_sh[r_len_m1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_len_m1    <= '1;
            r_bit_cnt   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= w_last_rise;
            frame_abort <= w_abort;
            if (w_start) begin
                r_len_m1  <= IW'(w_len - LW'(1));
                r_bit_cnt <= '0;
                r_rx_sh   <= '0;
                r_tx_sh   <= tx_valid ? tx_data : '0;
            end else if (r_state == S_SHIFT) begin
                if (w_sclk_rise) begin
                    r_rx_sh   <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + IW'(1);
                    if (w_last_rise) rx_data <= w_rx_next;
                end
                if (w_sclk_fall) r_tx_sh <= r_tx_sh << 1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [4:0]  n_bits;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_abort;
    logic        tx_underrun;

    int n_chk = 0;
    int n_bad = 0;
    int cnt_rx = 0, cnt_txr = 0, cnt_abort = 0, cnt_under = 0, n_wide = 0;
    logic p_rx = 0, p_txr = 0, p_ab = 0, p_un = 0;

    spi_slave #(.SPI_MAXLEN(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .n_bits(n_bits),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_abort(frame_abort), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    // Pulse counters; any pulse lasting two sampled cycles bumps n_wide.
    always @(negedge clk) begin
        if (rx_valid)    cnt_rx++;
        if (tx_ready)    cnt_txr++;
        if (frame_abort) cnt_abort++;
        if (tx_underrun) cnt_under++;
        if ((rx_valid && p_rx) || (tx_ready && p_txr) ||
            (frame_abort && p_ab) || (tx_underrun && p_un)) n_wide++;
        p_rx  = rx_valid;
        p_txr = tx_ready;
        p_ab  = frame_abort;
        p_un  = tx_underrun;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Master side: sclk = clk/8, mosi set on the low phase, miso sampled just before each rise.
    // After the accept window, tx_valid drops and tx_data is scrambled.
    task automatic xfer(input int npulse, input int len, input logic [15:0] word,
                        input bit raise, input int gap, output logic [15:0] got);
        got  = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 16'hDEAD;
        for (int i = 0; i < npulse; i++) begin
            mosi = (i < len) ? word[len-1-i] : 1'b0;
            repeat (4) @(negedge clk);
            got  = {got[14:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (raise) begin
            cs_n = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    logic [15:0] got, got2;
    int b_rx, b_txr, b_ab, b_un;

    task automatic snap();
        b_rx  = cnt_rx;
        b_txr = cnt_txr;
        b_ab  = cnt_abort;
        b_un  = cnt_under;
    endtask

    initial begin
        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        n_bits = 5'd8; tx_data = '0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_miso",    32'(miso), 32'h0);
        check_val("rst_miso_oe", 32'(miso_oe), 32'h0);
        check_val("rst_rx_data", 32'(rx_data), 32'h0);
        check_val("rst_pulses",  32'({rx_valid, tx_ready, frame_abort, tx_underrun}), 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 8-bit frame
        n_bits = 5'd8; tx_data = 16'h00A5; tx_valid = 1'b1; snap();
        xfer(8, 8, 16'h003C, 1, 8, got);
        check_val("t1_miso_word", 32'(got[7:0]), 32'hA5);
        check_val("t1_rx_data",   32'(rx_data), 32'h003C);
        check_val("t1_rx_pulses", 32'(cnt_rx - b_rx), 32'd1);
        check_val("t1_tx_ready",  32'(cnt_txr - b_txr), 32'd1);
        check_val("t1_oe_idle",   32'(miso_oe), 32'h0);

        // 2: n_bits=0 -> 16
        n_bits = 5'd0; tx_data = 16'hBEEF; tx_valid = 1'b1;
        xfer(16, 16, 16'h1234, 1, 8, got);
        check_val("t2_miso_word", 32'(got), 32'hBEEF);
        check_val("t2_rx_data",   32'(rx_data), 32'h1234);

        // n_bits above SPI_MAXLEN -> 16
        n_bits = 5'd20; tx_data = 16'hA55A; tx_valid = 1'b1;
        xfer(16, 16, 16'h0F0F, 1, 8, got);
        check_val("big_miso_word", 32'(got), 32'hA55A);
        check_val("big_rx_data",   32'(rx_data), 32'h0F0F);

        // 3: abort after 5 rises, then a good frame
        n_bits = 5'd8; tx_data = 16'h0081; tx_valid = 1'b1; snap();
        xfer(5, 8, 16'h00C3, 1, 8, got);
        check_val("t3_abort",     32'(cnt_abort - b_ab), 32'd1);
        check_val("t3_no_rx",     32'(cnt_rx - b_rx), 32'd0);
        check_val("t3_rx_kept",   32'(rx_data), 32'h0F0F);
        tx_data = 16'h000F; tx_valid = 1'b1;
        xfer(8, 8, 16'h0096, 1, 8, got);
        check_val("t3_next_rx",   32'(rx_data), 32'h0096);
        check_val("t3_next_miso", 32'(got[7:0]), 32'h0F);

        // 4: underrun
        tx_valid = 1'b0; tx_data = 16'h00AA; snap();
        xfer(8, 8, 16'h00FF, 1, 8, got);
        check_val("t4_underrun", 32'(cnt_under - b_un), 32'd1);
        check_val("t4_no_ready", 32'(cnt_txr - b_txr), 32'd0);
        check_val("t4_miso_zero", 32'(got[7:0]), 32'h00);
        check_val("t4_rx_data",  32'(rx_data), 32'h00FF);

        // 5: reset mid-frame
        tx_data = 16'h0033; tx_valid = 1'b1;
        xfer(3, 8, 16'h00A0, 0, 0, got);
        rst = 1'b0;
        #1;
        check_val("t5_miso",    32'(miso), 32'h0);
        check_val("t5_miso_oe", 32'(miso_oe), 32'h0);
        check_val("t5_rx_data", 32'(rx_data), 32'h0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tx_data = 16'h00C6; tx_valid = 1'b1;
        xfer(8, 8, 16'h005A, 1, 8, got);
        check_val("t5_rx_after", 32'(rx_data), 32'h005A);
        check_val("t5_miso_after", 32'(got[7:0]), 32'hC6);

        // 6: back-to-back with an extra sclk pulse, 4 clk gap
        tx_data = 16'h0022; tx_valid = 1'b1; snap();
        xfer(9, 8, 16'h0011, 1, 4, got);
        tx_data = 16'h0077; tx_valid = 1'b1;
        xfer(9, 8, 16'h00EE, 1, 8, got2);
        check_val("t6_miso_a",  32'(got[8:1]), 32'h22);
        check_val("t6_miso_b",  32'(got2[8:1]), 32'h77);
        check_val("t6_rx_cnt",  32'(cnt_rx - b_rx), 32'd2);
        check_val("t6_rx_data", 32'(rx_data), 32'h00EE);
        check_val("t6_no_abort", 32'(cnt_abort - b_ab), 32'd0);

        check_val("pulse_width", 32'(n_wide), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
